// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter width: max(1, clog2(width)) so WIDTH=1 still gets a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        if (width <= 1) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/FullAdderOneBit.sv
// Purely combinational one-bit full adder.
module FullAdderOneBit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder sequenced LSB-first over WIDTH cycles,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_a_q, shift_a_d;
    logic [WIDTH-1:0]  shift_b_q, shift_b_d;
    logic [WIDTH-1:0]  sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              c_out_q, c_out_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              fa_sum;
    logic              fa_cout;

    FullAdderOneBit u_fa (
        .a     (shift_a_q[0]),
        .b     (shift_b_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sum_sr_d  = sum_sr_q;
        sum_d     = sum_q;
        c_out_d   = c_out_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    carry_d   = c_in;
                    cnt_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                // New bit enters at the MSB; written this way so WIDTH=1 needs no special case.
                sum_sr_d            = sum_sr_q >> 1;
                sum_sr_d[WIDTH-1]   = fa_sum;
                carry_d             = fa_cout;
                cnt_d               = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    sum_d   = sum_sr_d;
                    c_out_d = fa_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_a_q <= '0;
            shift_b_q <= '0;
            sum_sr_q  <= '0;
            sum_q     <= '0;
            c_out_q   <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sum_sr_q  <= sum_sr_d;
            sum_q     <= sum_d;
            c_out_q   <= c_out_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
        end
    end

    // Handshake outputs depend on the state register only.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: three adder instances (WIDTH 8, 1, 32), table vectors,
// directed corner sequences and a random regression checked through a scoreboard queue.
module tb_serial_adder_ctrl;

    logic clk;
    logic rst_n;

    logic        iv  [3];
    logic        orr [3];
    logic [31:0] av  [3];
    logic [31:0] bv  [3];
    logic        ci  [3];

    logic        ir  [3];
    logic        ov  [3];
    logic        co  [3];
    logic [31:0] sm  [3];

    logic        ir_8, ov_8, co_8, ir_1, ov_1, co_1, ir_32, ov_32, co_32;
    logic [7:0]  sum_8;
    logic [0:0]  sum_1;
    logic [31:0] sum_32;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir_8),
        .a(av[0][7:0]), .b(bv[0][7:0]), .c_in(ci[0]), .out_valid(ov_8),
        .out_ready(orr[0]), .sum(sum_8), .c_out(co_8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir_1),
        .a(av[1][0:0]), .b(bv[1][0:0]), .c_in(ci[1]), .out_valid(ov_1),
        .out_ready(orr[1]), .sum(sum_1), .c_out(co_1)
    );

    serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir_32),
        .a(av[2]), .b(bv[2]), .c_in(ci[2]), .out_valid(ov_32),
        .out_ready(orr[2]), .sum(sum_32), .c_out(co_32)
    );

    always_comb begin
        ir[0] = ir_8;  ov[0] = ov_8;  co[0] = co_8;  sm[0] = {24'd0, sum_8};
        ir[1] = ir_1;  ov[1] = ov_1;  co[1] = co_1;  sm[1] = {31'd0, sum_1};
        ir[2] = ir_32; ov[2] = ov_32; co[2] = co_32; sm[2] = sum_32;
    end

    function automatic int wd(input int d);
        case (d)
            0:       return 8;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    // Reference model: {c_out, sum} of a+b+cin at width w.
    function automatic logic [32:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic cin);
        logic [63:0] mask;
        logic [63:0] full;
        mask = (64'd1 << w) - 64'd1;
        full = ({32'd0, x} & mask) + ({32'd0, y} & mask) + {63'd0, cin};
        return {full[w], full[31:0] & mask[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // One full transaction on instance d; rnd enables noise on ignored inputs.
    task automatic do_op(input int d, input logic [31:0] x, input logic [31:0] y,
                         input logic cin, input logic [32:0] exp, input int pre_gap,
                         input int hold, input bit rnd);
        int t;
        int lat;
        logic [32:0] e;
        repeat (pre_gap) tick();
        t = 0;
        while (!ir[d] && t < 50) begin
            tick();
            t++;
        end
        chk("in_ready_before_accept", {63'd0, ir[d]}, 64'd1);
        iv[d] = 1'b1; av[d] = x; bv[d] = y; ci[d] = cin;
        sb.push_back(exp);
        tick();
        iv[d] = 1'b0; av[d] = $urandom; bv[d] = $urandom; ci[d] = 1'($urandom);
        lat = 0;
        while (!ov[d] && lat < 40) begin
            if (rnd) begin
                iv[d]  = 1'($urandom);
                orr[d] = 1'($urandom);
                av[d]  = $urandom;
            end
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(wd(d)));
        e = sb.pop_front();
        for (int h = 0; h < hold; h++) begin
            orr[d] = 1'b0;
            iv[d]  = 1'($urandom);
            av[d]  = $urandom;
            bv[d]  = $urandom;
            chk("hold_out_valid", {63'd0, ov[d]}, 64'd1);
            chk("hold_in_ready", {63'd0, ir[d]}, 64'd0);
            chk("hold_sum", {32'd0, sm[d]}, {32'd0, e[31:0]});
            tick();
        end
        chk("sum", {32'd0, sm[d]}, {32'd0, e[31:0]});
        chk("c_out", {63'd0, co[d]}, {63'd0, e[32]});
        orr[d] = 1'b1;
        tick();
        orr[d] = 1'b0;
        iv[d]  = 1'b0;
        chk("in_ready_after_result", {63'd0, ir[d]}, 64'd1);
        chk("out_valid_after_result", {63'd0, ov[d]}, 64'd0);
    endtask

    typedef struct {
        int          d;
        logic [31:0] x;
        logic [31:0] y;
        logic        cin;
        logic [31:0] esum;
        logic        ecout;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{0, 32'h5A, 32'h33, 1'b0, 32'h8D, 1'b0};
        tbl[1]  = '{0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1};
        tbl[2]  = '{0, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1};
        tbl[3]  = '{0, 32'h00, 32'h00, 1'b1, 32'h01, 1'b0};
        tbl[4]  = '{1, 32'h1,  32'h1,  1'b1, 32'h1,  1'b1};
        tbl[5]  = '{1, 32'h0,  32'h0,  1'b0, 32'h0,  1'b0};
        tbl[6]  = '{1, 32'h1,  32'h0,  1'b0, 32'h1,  1'b0};
        tbl[7]  = '{2, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1};
        tbl[8]  = '{2, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1};
        tbl[9]  = '{2, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
        tbl[10] = '{0, 32'h80, 32'h7F, 1'b1, 32'h00, 1'b1};

        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; orr[d] = 1'b0; av[d] = '0; bv[d] = '0; ci[d] = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk("reset_out_valid", {63'd0, ov[d]}, 64'd0);
            chk("reset_in_ready", {63'd0, ir[d]}, 64'd1);
            chk("reset_sum", {32'd0, sm[d]}, 64'd0);
            chk("reset_c_out", {63'd0, co[d]}, 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // Table vectors, with a 5-cycle backpressure hold on the first.
        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].d, tbl[i].x, tbl[i].y, tbl[i].cin, {tbl[i].ecout, tbl[i].esum},
                  0, (i == 0) ? 5 : 0, 1'b0);
        end

        // Reset while cnt == 3: the aborted op must never produce a result.
        iv[0] = 1'b1; av[0] = 32'hAB; bv[0] = 32'hCD; ci[0] = 1'b1; orr[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_state_out_valid", {63'd0, ov[0]}, 64'd0);
        chk("abort_in_ready", {63'd0, ir[0]}, 64'd1);
        chk("abort_sum", {32'd0, sm[0]}, 64'd0);
        chk("abort_c_out", {63'd0, co[0]}, 64'd0);
        begin
            int seen = 0;
            for (int k = 0; k < 12; k++) begin
                if (ov[0]) seen++;
                tick();
            end
            chk("abort_no_out_valid", 64'(seen), 64'd0);
        end
        orr[0] = 1'b0;
        do_op(0, 32'h10, 32'h20, 1'b1, {1'b0, 32'h31}, 0, 0, 1'b0);

        // Random regression on WIDTH 8 and 32.
        for (int d = 0; d < 3; d += 2) begin
            for (int i = 0; i < 500; i++) begin
                logic [31:0] x;
                logic [31:0] y;
                logic        cin;
                x   = $urandom;
                y   = $urandom;
                cin = 1'($urandom);
                if (i % 7 == 0) x = '1;
                do_op(d, x, y, cin, model(wd(d), x, y, cin), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b1);
            end
        end
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder controller. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It then sequences a single one-bit full adder LSB-first over WIDTH cycles, holding the running carry in a flop. The result is presented over a second valid/ready handshake. The block sits between an operand producer and a result consumer wherever area matters more than throughput.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  in  1  operands a, b, c_in valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  initial carry-in.
- out_valid  out  1  sum/c_out valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  registered result, a+b+c_in mod 2^WIDTH.
- c_out  out  1  registered final carry-out.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&in_ready: load shift_a<=a, shift_b<=b, carry<=c_in, cnt<=0; go to RUN.
- **RUN**
  - Full adder inputs are shift_a[0], shift_b[0], carry.
  - Each edge:
    - shift_a and shift_b shift right by 1.
    - sum_sr<={fa_sum, sum_sr[WIDTH-1:1]}.
    - carry<=fa_cout.
    - cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: c_out<=fa_cout, sum<=final sum_sr value; go to DONE.
- **DONE**
  - out_valid=1; sum and c_out held stable.
  - On out_valid&out_ready: go to IDLE.
- in_valid outside IDLE is ignored; no operands are captured.
- out_ready outside DONE is ignored.
- Arithmetic is unsigned. sum is exactly the low WIDTH bits of a+b+c_in; c_out is bit WIDTH.
- cnt width is max(1, clog2(WIDTH)). No wrap-around occurs because the terminal compare is exact.
- WIDTH=1: RUN lasts one cycle.

## Timing
- Reset (rst_n=0 at an edge), from any state:
  - state<=IDLE.
  - sum<=0, c_out<=0, carry<=0, cnt<=0, shift registers <=0.
  - After the reset edge: out_valid=0, in_ready=1.
- Reset mid-RUN or in DONE aborts the operation. No out_valid is produced for it and the result is discarded.
- Latency: if operands are accepted at edge E0, out_valid is high in the cycle following edge E_WIDTH, i.e. after WIDTH RUN edges.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH RUN, at least one DONE cycle. A result handshake and a new operand accept cannot occur in the same cycle.
- in_ready and out_valid are decoded combinationally from the state register only. They have no combinational path from in_valid or out_ready.
- Operand inputs are sampled only at the accept edge. They may change freely afterwards.

## Structure
- Package serial_add_pkg holds:
  - typedef enum for state {IDLE, RUN, DONE}, 2-bit encoding.
  - function cnt_width(WIDTH) returning max(1, clog2(WIDTH)).
- Sub-module: the existing one-bit full adder FullAdderOneBit (ports a, b, c_in, sum, c_out). It is instantiated once, unregistered. All other logic is inline in serial_adder_ctrl.

## Test plan
1. WIDTH=8, a=0x5A, b=0x33, c_in=0, out_ready=1 → out_valid exactly 8 cycles after accept, sum=0x8D, c_out=0, then in_ready=1 next cycle.
2. WIDTH=8, a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1. Then a=0xFF, b=0xFF, c_in=1 → sum=0xFF, c_out=1.
3. Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, sum and c_out unchanged, in_ready=0. Toggling in_valid with new operands has no effect on the pending result.
4. Reset mid-run: drive rst_n=0 for one edge when cnt=3 → next cycle state IDLE, out_valid=0, sum=0, c_out=0, in_ready=1. The next op a=0x10, b=0x20, c_in=1 gives sum=0x31.
5. WIDTH=1, a=1, b=1, c_in=1 → out_valid one cycle after accept, sum=1, c_out=1.
6. Random regression, WIDTH=8 and WIDTH=32, 1000 ops with random in_valid/out_ready gaps → every result matches a+b+c_in; no dropped or duplicated handshakes.
